// File: rtl/class_accum_seq.sv
// class_accum_seq
// Accumulates binary hypervectors into per-class saturating counters, one
// chunk of CHUNK_W dimensions per clock, and exposes any class's counters and
// their thresholded (binarised) form combinationally.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   nrst      : asynchronous active-low reset
//   in_valid  : request to accumulate in_hv into class in_class
//   in_ready  : high in IDLE when no clear is requested
//   in_class  : target class of the request
//   in_hv     : binary hypervector to add/subtract
//   in_sub    : 0 = add, 1 = subtract
//   clr_all   : clear every counter (honoured only in IDLE)
//   busy      : request in progress (PROC or FIN)
//   done      : one-cycle pulse in FIN
//   err       : one-cycle pulse with done when the class was out of range
//   rd_class  : class selected for readout
//   rd_nb     : counters of rd_class, dimension k at [k*CNT_W +: CNT_W]
//   rd_bin    : bit k set iff counter k >= THRESH
module class_accum_seq #(
  parameter int HV_W      = 50,
  parameter int CHUNK_W   = 5,
  parameter int NUM_CLASS = 26,
  parameter int CLS_W     = 5,
  parameter int CNT_W     = 8,
  parameter int THRESH    = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CLS_W-1:0]        in_class,
  input  logic [HV_W-1:0]         in_hv,
  input  logic                    in_sub,
  input  logic                    clr_all,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [CLS_W-1:0]        rd_class,
  output logic [HV_W*CNT_W-1:0]   rd_nb,
  output logic [HV_W-1:0]         rd_bin
);

  localparam int NCHUNK = HV_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
  // One extra bit so NUM_CLASS == 2^CLS_W is still representable.
  localparam logic [CLS_W:0]   NUM_CLASS_C = (CLS_W + 1)'(NUM_CLASS);

  typedef enum logic [1:0] {IDLE, PROC, FIN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CLS_W-1:0]  lat_class;
  logic [HV_W-1:0]   lat_hv;
  logic              lat_sub;

  logic              clr;
  logic              proc;
  logic [NCHUNK-1:0] chunk_sel;
  logic [NUM_CLASS-1:0] class_sel;
  logic [HV_W*CNT_W-1:0] rows [NUM_CLASS];

  assign in_ready = (state == IDLE) && !clr_all;
  assign busy     = (state != IDLE);
  assign clr      = (state == IDLE) && clr_all;
  assign proc     = (state == PROC);

  // Control FSM; request fields are latched on acceptance so later input
  // changes cannot disturb the request in progress.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      idx       <= '0;
      lat_class <= '0;
      lat_hv    <= '0;
      lat_sub   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !clr_all) begin
            lat_class <= in_class;
            lat_hv    <= in_hv;
            lat_sub   <= in_sub;
            idx       <= '0;
            state     <= PROC;
          end
        end
        PROC: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= FIN;
            done  <= 1'b1;
            err   <= ({1'b0, lat_class} >= NUM_CLASS_C);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  genvar gi, gj;

  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk_sel
      assign chunk_sel[gi] = (idx == IDX_W'(gi));
    end

    // An out-of-range latched class matches no row, so nothing changes.
    for (gi = 0; gi < NUM_CLASS; gi++) begin : g_class
      logic [HV_W*CNT_W-1:0] row;

      assign class_sel[gi] = (lat_class == CLS_W'(gi));

      for (gj = 0; gj < HV_W; gj++) begin : g_dim
        logic [CNT_W-1:0] ctr;
        logic             hit;

        assign hit = proc && class_sel[gi] && chunk_sel[gj / CHUNK_W] && lat_hv[gj];

        // Saturating up/down counter: holds at 0 and at all-ones.
        always_ff @(posedge clk or negedge nrst) begin
          if (!nrst) begin
            ctr <= '0;
          end else if (clr) begin
            ctr <= '0;
          end else if (hit) begin
            if (lat_sub) begin
              if (ctr != '0) ctr <= ctr - 1'b1;
            end else begin
              if (ctr != CNT_MAX) ctr <= ctr + 1'b1;
            end
          end
        end

        assign row[gj*CNT_W +: CNT_W] = ctr;
      end

      assign rows[gi] = row;
    end
  endgenerate

  // Readout mux; classes beyond NUM_CLASS fall through to zero.
  always_comb begin
    rd_nb = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (rd_class == CLS_W'(c)) rd_nb = rows[c];
    end
  end

  generate
    for (gi = 0; gi < HV_W; gi++) begin : g_bin
      assign rd_bin[gi] = (rd_nb[gi*CNT_W +: CNT_W] >= THRESH_C);
    end
  endgenerate

endmodule

// File: tb/tb_class_accum_seq.sv
// Self-checking bench for class_accum_seq: default-parameter instance driven
// with directed and random requests against a per-dimension counter model,
// plus a second instance with a wider/coarser parameter set.
module tb_class_accum_seq;

  localparam int HV_W      = 50;
  localparam int CNT_W     = 8;
  localparam int NUM_CLASS = 26;
  localparam int CLS_W     = 5;
  localparam int NCH       = 10;
  localparam int CNT_MAXV  = 255;

  localparam int HV2   = 64;
  localparam int CNT2  = 4;
  localparam int NCH2  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  nrst;
  logic                  in_valid, in_ready, in_sub, clr_all, busy, done, err;
  logic [CLS_W-1:0]      in_class, rd_class;
  logic [HV_W-1:0]       in_hv, rd_bin;
  logic [HV_W*CNT_W-1:0] rd_nb;

  logic                  in_valid2, in_ready2, in_sub2, clr_all2, busy2, done2, err2;
  logic [CLS_W-1:0]      in_class2, rd_class2;
  logic [HV2-1:0]        in_hv2, rd_bin2;
  logic [HV2*CNT2-1:0]   rd_nb2;

  class_accum_seq dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_hv(in_hv), .in_sub(in_sub), .clr_all(clr_all),
    .busy(busy), .done(done), .err(err), .rd_class(rd_class),
    .rd_nb(rd_nb), .rd_bin(rd_bin)
  );

  class_accum_seq #(.HV_W(64), .CHUNK_W(8), .NUM_CLASS(26), .CLS_W(5),
                    .CNT_W(4), .THRESH(3)) dut2 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_class(in_class2), .in_hv(in_hv2), .in_sub(in_sub2), .clr_all(clr_all2),
    .busy(busy2), .done(done2), .err(err2), .rd_class(rd_class2),
    .rd_nb(rd_nb2), .rd_bin(rd_bin2)
  );

  int checks   = 0;
  int failures = 0;
  int mdl [32][HV_W];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HV_W-1:0] rand_hv();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[HV_W-1:0];
  endfunction

  task automatic mdl_clear();
    for (int c = 0; c < 32; c++)
      for (int d = 0; d < HV_W; d++) mdl[c][d] = 0;
  endtask

  // Reference: each set bit moves that dimension's count by one, clamped to
  // [0, 2^CNT_W-1]; out-of-range classes are untouched.
  task automatic mdl_apply(input int cls, input logic [HV_W-1:0] hv, input bit sub);
    if (cls < NUM_CLASS) begin
      for (int d = 0; d < HV_W; d++) begin
        if (hv[d]) begin
          if (sub) mdl[cls][d] = (mdl[cls][d] > 0) ? mdl[cls][d] - 1 : 0;
          else     mdl[cls][d] = (mdl[cls][d] < CNT_MAXV) ? mdl[cls][d] + 1 : CNT_MAXV;
        end
      end
    end
  endtask

  task automatic check_class(input int c);
    logic [HV_W*CNT_W-1:0] exp_nb;
    logic [HV_W-1:0]       exp_bin;
    rd_class = CLS_W'(c);
    #1;
    for (int d = 0; d < HV_W; d++) begin
      exp_nb[d*CNT_W +: CNT_W] = CNT_W'(mdl[c][d]);
      exp_bin[d] = (mdl[c][d] >= 1);
    end
    chk($sformatf("rd_nb_class%0d", c), rd_nb, exp_nb);
    chk($sformatf("rd_bin_class%0d", c), rd_bin, exp_bin);
  endtask

  // One request; with poke set, inputs are scrambled and clr_all raised
  // while the request runs, which must not disturb it.
  task automatic do_req(input int cls, input logic [HV_W-1:0] hv, input bit sub, input bit poke);
    int n, bc, rc;
    bit seen, e;
    sync();
    n = 0;
    while (!in_ready && n < 50) begin
      sync();
      n++;
    end
    in_valid = 1'b1;
    in_class = CLS_W'(cls);
    in_hv    = hv;
    in_sub   = sub;
    sync();
    in_valid = 1'b0;
    if (poke) begin
      in_class = CLS_W'($urandom);
      in_hv    = rand_hv();
      in_sub   = ~sub;
      clr_all  = 1'b1;
    end
    n = 1; bc = 0; rc = 0; seen = 1'b0; e = 1'b0;
    while (n <= 40) begin
      if (busy) bc++;
      if (in_ready) rc++;
      if (done) begin
        seen = 1'b1;
        e    = err;
        break;
      end
      sync();
      n++;
    end
    clr_all = 1'b0;
    chk($sformatf("latency_c%0d", cls), seen ? n : 0, NCH + 1);
    chk("busy_cycles", bc, NCH + 1);
    chk("ready_while_busy", rc, 0);
    chk($sformatf("err_c%0d", cls), e, (cls >= NUM_CLASS));
    sync();
    chk("after_done_idle", {done, err, busy}, 3'b000);
    mdl_apply(cls, hv, sub);
  endtask

  task automatic do_req2(input int k);
    int n;
    logic [HV2*CNT2-1:0] exp_nb;
    logic [HV2-1:0]      exp_bin;
    int cnt;
    sync();
    in_valid2 = 1'b1;
    in_class2 = 5'd2;
    in_hv2    = '1;
    in_sub2   = 1'b0;
    sync();
    in_valid2 = 1'b0;
    n = 1;
    while (!done2 && n < 40) begin
      sync();
      n++;
    end
    chk($sformatf("p2_latency_k%0d", k), n, NCH2 + 1);
    sync();
    cnt = (k < 15) ? k : 15;
    for (int d = 0; d < HV2; d++) begin
      exp_nb[d*CNT2 +: CNT2] = CNT2'(cnt);
      exp_bin[d] = (cnt >= 3);
    end
    rd_class2 = 5'd2;
    #1;
    chk($sformatf("p2_rd_nb_k%0d", k), rd_nb2, exp_nb);
    chk($sformatf("p2_rd_bin_k%0d", k), rd_bin2, exp_bin);
  endtask

  initial begin : main
    int n;
    nrst = 1'b0;
    in_valid = 1'b0; in_class = '0; in_hv = '0; in_sub = 1'b0; clr_all = 1'b0; rd_class = '0;
    in_valid2 = 1'b0; in_class2 = '0; in_hv2 = '0; in_sub2 = 1'b0; clr_all2 = 1'b0; rd_class2 = '0;
    mdl_clear();

    #3;
    chk("reset_outputs", {busy, done, err, in_ready}, 4'b0001);
    check_class(3);
    repeat (2) @(posedge clk);
    #4 nrst = 1'b1;

    // Single add of all-ones into class 3.
    do_req(3, '1, 1'b0, 1'b0);
    check_class(3);

    // Saturation on add, then back down to zero.
    repeat (300) do_req(3, '1, 1'b0, 1'($urandom));
    check_class(3);
    repeat (300) do_req(3, '1, 1'b1, 1'($urandom));
    check_class(3);
    chk("rd_bin_zero_after_subs", rd_bin, '0);

    // Single dimension into first and last classes.
    do_req(0, 50'h1, 1'b0, 1'b0);
    do_req(25, 50'h1, 1'b0, 1'b0);
    check_class(0);
    check_class(25);
    check_class(1);

    // Out-of-range class: err with done, no counter change.
    do_req(30, rand_hv(), 1'b0, 1'b1);
    for (int c = 0; c < 32; c++) check_class(c);

    // in_valid held high through the request: one acceptance until after FIN.
    sync();
    in_valid = 1'b1; in_class = 5'd30; in_hv = rand_hv(); in_sub = 1'b0;
    sync();
    n = 1;
    while (!done && n < 40) begin
      sync();
      n++;
    end
    chk("held_valid_latency", n, NCH + 1);
    sync();
    chk("held_valid_idle_after_fin", {busy, in_ready}, 2'b01);
    sync();
    chk("held_valid_second_accept", busy, 1'b1);
    in_valid = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      sync();
      n++;
    end
    chk("held_valid_second_done", {n == NCH + 1, err}, 2'b11);

    // Random traffic, including subtracts and out-of-range classes.
    for (int i = 0; i < 60; i++) begin
      do_req($urandom_range(0, 27), rand_hv(), ($urandom_range(0, 3) == 0), 1'($urandom));
      check_class($urandom_range(0, 31));
    end

    // Reset mid-request (during chunk 4).
    sync();
    in_valid = 1'b1; in_class = 5'd5; in_hv = '1; in_sub = 1'b0;
    sync();
    in_valid = 1'b0;
    repeat (4) sync();
    nrst = 1'b0;
    #1;
    chk("mid_reset_outputs", {busy, done, err}, 3'b000);
    sync();
    nrst = 1'b1;
    #1;
    chk("ready_after_release", {in_ready, busy}, 2'b10);
    n = 0;
    repeat (15) begin
      sync();
      if (done) n++;
    end
    chk("no_done_after_reset", n, 0);
    mdl_clear();
    for (int c = 0; c < NUM_CLASS; c++) check_class(c);

    // clr_all in IDLE wipes everything and ignores in_valid.
    do_req(7, rand_hv() | 50'h1, 1'b0, 1'b0);
    do_req(3, '1, 1'b0, 1'b0);
    check_class(7);
    sync();
    clr_all = 1'b1; in_valid = 1'b1; in_class = 5'd7; in_hv = '1; in_sub = 1'b0;
    #1;
    chk("ready_low_during_clr", in_ready, 1'b0);
    sync();
    clr_all = 1'b0; in_valid = 1'b0;
    chk("clr_ignores_valid", busy, 1'b0);
    mdl_clear();
    check_class(7);
    check_class(3);

    // Second parameter set.
    for (int k = 1; k <= 18; k++) do_req2(k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
